// File: rtl/flag_branch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// flag_branch_ctrl_pkg
// Shared definitions for the flag/branch controller slice:
//   - state_t         : controller FSM state encodings
//   - FLAG_REG_WIDTH  : number of implemented flag bits (default FLAG_W)
//   - FLAG_IDX_*      : architectural flag index constants
//   - flag_code_valid : true when a branch flag code names an implemented flag
// ---------------------------------------------------------------------------
package flag_branch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int FLAG_REG_WIDTH = 6;
    localparam int FLAG_CODE_W    = 5;

    localparam logic [FLAG_CODE_W-1:0] FLAG_IDX_CARRY  = 5'd0;
    localparam logic [FLAG_CODE_W-1:0] FLAG_IDX_ZERO   = 5'd1;
    localparam logic [FLAG_CODE_W-1:0] FLAG_IDX_NEG    = 5'd2;
    localparam logic [FLAG_CODE_W-1:0] FLAG_IDX_OVF    = 5'd3;
    localparam logic [FLAG_CODE_W-1:0] FLAG_IDX_PARITY = 5'd4;
    localparam logic [FLAG_CODE_W-1:0] FLAG_IDX_USER   = 5'd5;

    // Codes at or beyond the implemented width never satisfy a jt or a jf.
    function automatic logic flag_code_valid(input logic [FLAG_CODE_W-1:0] code,
                                             input int                     flag_w);
        return (int'(code) < flag_w);
    endfunction

endpackage

// File: rtl/flag_branch_ctrl_scoreboard.sv
// ---------------------------------------------------------------------------
// flag_scoreboard
// Tracks flag-writing instructions between leaving ID and their FMU commit.
// One bit per pipeline slot; bit 0 is the youngest writer, the MSB is the
// writer committing this cycle.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   issue       : a flag writer leaves ID this cycle
//   fmu_we      : oldest slot occupied -> FMU captures flags this cycle
//   empty       : no writer in flight, FMU flags are architectural
//   last_only   : only the committing writer remains in flight
// ---------------------------------------------------------------------------
module flag_scoreboard
    import flag_branch_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH = 3
)(
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    output logic fmu_we,
    output logic empty,
    output logic last_only
);

    logic [PIPE_DEPTH-1:0] pend;

    // Every cycle the in-flight writers move one slot closer to commit and
    // either a new writer or a bubble enters slot 0. Shifting rather than
    // concatenating keeps PIPE_DEPTH = 1 legal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend << 1) | PIPE_DEPTH'(issue);
        end
    end

    // Status decode for the controller.
    always_comb begin
        fmu_we    = pend[PIPE_DEPTH-1];
        empty     = (pend == '0);
        last_only = (pend == (PIPE_DEPTH'(1) << (PIPE_DEPTH-1)));
    end

endmodule

// File: rtl/flag_branch_ctrl.sv
// ---------------------------------------------------------------------------
// flag_branch_ctrl
// Sequences the flag management unit (FMU) for conditional jumps (jt/jf).
// Holds a branch in ID until every older flag writer has committed, then
// resolves it and flushes the front end for FLUSH_CYCLES cycles when taken.
// Optional feature macro: FLAG_FWD_EN -- resolve in the commit cycle of the
// last in-flight writer using wb_flags directly, saving one stall cycle.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   id_valid         : valid instruction in ID
//   id_is_branch     : ID instruction is jt/jf
//   id_sel_jt_jf     : 1 = jt, 0 = jf
//   id_flag_code     : flag index tested by the branch
//   id_writes_flags  : ID instruction updates flags
//   wb_flags         : ALU flags at commit (FMU flags_in)
//   fmu_jt_jf_ok     : FMU condition result
//   fmu_we           : FMU write enable
//   fmu_flag_code    : flag select to FMU
//   fmu_sel_jt_jf    : jt/jf select to FMU
//   stall, flush     : hold / kill IF-ID
//   br_resolved      : one-cycle pulse when the branch is decided
//   br_taken         : decision, valid with br_resolved
// ---------------------------------------------------------------------------
module flag_branch_ctrl
    import flag_branch_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH   = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int FLAG_W       = FLAG_REG_WIDTH
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_is_branch,
    input  logic              id_sel_jt_jf,
    input  logic [4:0]        id_flag_code,
    input  logic              id_writes_flags,
    input  logic [FLAG_W-1:0] wb_flags,
    input  logic              fmu_jt_jf_ok,
    output logic              fmu_we,
    output logic [4:0]        fmu_flag_code,
    output logic              fmu_sel_jt_jf,
    output logic              stall,
    output logic              flush,
    output logic              br_resolved,
    output logic              br_taken
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [4:0]         code_q, code_nxt;
    logic               sel_q, sel_nxt;

    logic               sb_we, sb_empty, sb_last_only;
    logic               issue;
    logic [4:0]         cur_code;
    logic               cur_sel;
    logic               cond_fmu, cond_fwd, can_fwd;
    logic               ready, taken;

    // A branch never counts as a writer, and nothing issues while ID is held
    // or being killed.
    assign issue = id_valid & id_writes_flags & ~id_is_branch & ~stall & ~flush;

    flag_scoreboard #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue),
        .fmu_we    (sb_we),
        .empty     (sb_empty),
        .last_only (sb_last_only)
    );

    // Keep the FMU quiet while reset is held, even if a writer was about to
    // commit.
    assign fmu_we = sb_we & rst_n;

    // While waiting, the FMU must keep looking at the stalled branch's code,
    // not whatever the decoder presents; otherwise it follows ID.
    always_comb begin
        cur_code = id_flag_code;
        cur_sel  = id_sel_jt_jf;
        if (rst_n && state == ST_WAIT) begin
            cur_code = code_q;
            cur_sel  = sel_q;
        end
        fmu_flag_code = cur_code;
        fmu_sel_jt_jf = cur_sel;
    end

    assign cond_fmu = flag_code_valid(cur_code, FLAG_W) & fmu_jt_jf_ok;

`ifdef FLAG_FWD_EN
    // Bypass path: the committing writer's flags are on wb_flags this cycle,
    // so evaluate jt/jf on them directly instead of waiting for the FMU.
    logic [31:0] wb_ext;
    logic        wb_bit;
    assign wb_ext   = 32'(wb_flags);
    assign wb_bit   = wb_ext[cur_code];
    assign cond_fwd = flag_code_valid(cur_code, FLAG_W) & (cur_sel ? wb_bit : ~wb_bit);
    assign can_fwd  = sb_last_only;
`else
    logic unused_fwd;
    assign unused_fwd = ^{wb_flags, sb_last_only};
    assign cond_fwd   = 1'b0;
    assign can_fwd    = 1'b0;
`endif

    assign ready = sb_empty | can_fwd;
    assign taken = sb_empty ? cond_fmu : cond_fwd;

    // Next-state and control outputs. A resolution in IDLE or WAIT is handled
    // uniformly after the case: a taken branch always enters FLUSH with a
    // freshly loaded counter.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        code_nxt    = code_q;
        sel_nxt     = sel_q;
        stall       = 1'b0;
        flush       = 1'b0;
        br_resolved = 1'b0;
        br_taken    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (id_valid && id_is_branch) begin
                    if (ready) begin
                        br_resolved = 1'b1;
                        br_taken    = taken;
                    end else begin
                        code_nxt  = id_flag_code;
                        sel_nxt   = id_sel_jt_jf;
                        stall     = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (ready) begin
                    br_resolved = 1'b1;
                    br_taken    = taken;
                    state_nxt   = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            ST_FLUSH: begin
                flush   = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (br_resolved && br_taken) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = CNT_W'(FLUSH_CYCLES);
        end

        // Reset wins immediately over any in-progress wait or flush.
        if (!rst_n) begin
            stall       = 1'b0;
            flush       = 1'b0;
            br_resolved = 1'b0;
            br_taken    = 1'b0;
        end
    end

    // State, flush counter and latched branch operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            code_q <= '0;
            sel_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            code_q <= code_nxt;
            sel_q  <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_flag_branch_ctrl
// Cycle table for flag_branch_ctrl: each row is one cycle of ID/commit inputs
// and the control outputs expected in that same cycle. A small FMU model
// captures wb_flags on fmu_we and answers jt/jf queries; for unimplemented
// codes it deliberately answers "true" so the controller must mask it.
// ---------------------------------------------------------------------------
module tb_flag_branch_ctrl;

    typedef struct {
        string      name;
        logic       rst;
        logic       valid;
        logic       br;
        logic       sel;
        logic [4:0] code;
        logic       wr;
        logic [5:0] wb;
        logic       e_stall;
        logic       e_flush;
        logic       e_res;
        logic       e_taken;
        logic       e_we;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_is_branch, id_sel_jt_jf, id_writes_flags;
    logic [4:0] id_flag_code;
    logic [5:0] wb_flags;
    logic       fmu_jt_jf_ok;
    logic       fmu_we, fmu_sel_jt_jf, stall, flush, br_resolved, br_taken;
    logic [4:0] fmu_flag_code;

    logic [5:0]  fmu_flags = '0;
    logic [31:0] fmu_ext;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    flag_branch_ctrl #(
        .PIPE_DEPTH   (3),
        .FLUSH_CYCLES (2),
        .FLAG_W       (6)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_is_branch    (id_is_branch),
        .id_sel_jt_jf    (id_sel_jt_jf),
        .id_flag_code    (id_flag_code),
        .id_writes_flags (id_writes_flags),
        .wb_flags        (wb_flags),
        .fmu_jt_jf_ok    (fmu_jt_jf_ok),
        .fmu_we          (fmu_we),
        .fmu_flag_code   (fmu_flag_code),
        .fmu_sel_jt_jf   (fmu_sel_jt_jf),
        .stall           (stall),
        .flush           (flush),
        .br_resolved     (br_resolved),
        .br_taken        (br_taken)
    );

    // FMU model: flag register written on fmu_we, combinational jt/jf test.
    always @(posedge clk) begin
        if (fmu_we) fmu_flags <= wb_flags;
    end

    assign fmu_ext = 32'(fmu_flags);

    always_comb begin
        if (fmu_flag_code < 5'd6)
            fmu_jt_jf_ok = fmu_sel_jt_jf ? fmu_ext[fmu_flag_code] : ~fmu_ext[fmu_flag_code];
        else
            fmu_jt_jf_ok = 1'b1;
    end

    task automatic addVec(input string name, input logic rst, input logic valid,
                          input logic br, input logic sel, input logic [4:0] code,
                          input logic wr, input logic [5:0] wb,
                          input logic e_stall, input logic e_flush, input logic e_res,
                          input logic e_taken, input logic e_we);
        vec_t v;
        v.name = name; v.rst = rst; v.valid = valid; v.br = br; v.sel = sel;
        v.code = code; v.wr = wr; v.wb = wb;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_res = e_res;
        v.e_taken = e_taken; v.e_we = e_we;
        vecs.push_back(v);
    endtask

    task automatic buildTable();
        //      name      rst v br s code wr wb           st fl rs tk we
        addVec("rst0",    0, 0, 0, 0, 5'd0, 0, 6'b000000, 0, 0, 0, 0, 0);
        addVec("rst_br",  0, 1, 1, 1, 5'd0, 0, 6'b000000, 0, 0, 0, 0, 0);
        addVec("rst_wr",  0, 1, 0, 0, 5'd0, 1, 6'b000000, 0, 0, 0, 0, 0);
        // Load flags 000001, then an unstalled taken jt on flag 0.
        addVec("A_wr",    1, 1, 0, 0, 5'd0, 1, 6'b000001, 0, 0, 0, 0, 0);
        addVec("A_n1",    1, 0, 0, 0, 5'd0, 0, 6'b000001, 0, 0, 0, 0, 0);
        addVec("A_n2",    1, 0, 0, 0, 5'd0, 0, 6'b000001, 0, 0, 0, 0, 0);
        addVec("A_n3",    1, 0, 0, 0, 5'd0, 0, 6'b000001, 0, 0, 0, 0, 1);
        addVec("A_br",    1, 1, 1, 1, 5'd0, 0, 6'b000001, 0, 0, 1, 1, 0);
        addVec("A_f1",    1, 1, 0, 0, 5'd0, 1, 6'b000001, 0, 1, 0, 0, 0);
        addVec("A_f2",    1, 1, 0, 0, 5'd0, 1, 6'b000001, 0, 1, 0, 0, 0);
        addVec("A_n4",    1, 0, 0, 0, 5'd0, 0, 6'b000001, 0, 0, 0, 0, 0);
        addVec("A_n5",    1, 0, 0, 0, 5'd0, 0, 6'b000001, 0, 0, 0, 0, 0);
        addVec("A_n6",    1, 0, 0, 0, 5'd0, 0, 6'b000001, 0, 0, 0, 0, 0);
        // Writer then jt on flag 1 right behind it.
        addVec("B_wr",    1, 1, 0, 0, 5'd0, 1, 6'b000010, 0, 0, 0, 0, 0);
        addVec("B_br1",   1, 1, 1, 1, 5'd1, 0, 6'b000010, 1, 0, 0, 0, 0);
        addVec("B_br2",   1, 1, 1, 1, 5'd1, 0, 6'b000010, 1, 0, 0, 0, 0);
`ifdef FLAG_FWD_EN
        addVec("B_br3",   1, 1, 1, 1, 5'd1, 0, 6'b000010, 0, 0, 1, 1, 1);
`else
        addVec("B_br3",   1, 1, 1, 1, 5'd1, 0, 6'b000010, 1, 0, 0, 0, 1);
        addVec("B_br4",   1, 1, 1, 1, 5'd1, 0, 6'b000010, 0, 0, 1, 1, 0);
`endif
        addVec("B_f1",    1, 0, 0, 0, 5'd0, 0, 6'b000010, 0, 1, 0, 0, 0);
        addVec("B_f2",    1, 0, 0, 0, 5'd0, 0, 6'b000010, 0, 1, 0, 0, 0);
        addVec("B_n",     1, 0, 0, 0, 5'd0, 0, 6'b000010, 0, 0, 0, 0, 0);
        // Flags 000100: jf on flag 2 falls through, then jt on flag 2 from IDLE.
        addVec("C_wr",    1, 1, 0, 0, 5'd0, 1, 6'b000100, 0, 0, 0, 0, 0);
        addVec("C_n1",    1, 0, 0, 0, 5'd0, 0, 6'b000100, 0, 0, 0, 0, 0);
        addVec("C_n2",    1, 0, 0, 0, 5'd0, 0, 6'b000100, 0, 0, 0, 0, 0);
        addVec("C_n3",    1, 0, 0, 0, 5'd0, 0, 6'b000100, 0, 0, 0, 0, 1);
        addVec("C_jf2",   1, 1, 1, 0, 5'd2, 0, 6'b000100, 0, 0, 1, 0, 0);
        addVec("C_jt2",   1, 1, 1, 1, 5'd2, 0, 6'b000100, 0, 0, 1, 1, 0);
        addVec("C_f1",    1, 0, 0, 0, 5'd0, 0, 6'b000100, 0, 1, 0, 0, 0);
        addVec("C_f2",    1, 0, 0, 0, 5'd0, 0, 6'b000100, 0, 1, 0, 0, 0);
        addVec("C_n",     1, 0, 0, 0, 5'd0, 0, 6'b000100, 0, 0, 0, 0, 0);
        // Three back-to-back writers; only the last one sets flag 3.
        addVec("D_w0",    1, 1, 0, 0, 5'd0, 1, 6'b110111, 0, 0, 0, 0, 0);
        addVec("D_w1",    1, 1, 0, 0, 5'd0, 1, 6'b110111, 0, 0, 0, 0, 0);
        addVec("D_w2",    1, 1, 0, 0, 5'd0, 1, 6'b110111, 0, 0, 0, 0, 0);
        addVec("D_b3",    1, 1, 1, 1, 5'd3, 0, 6'b110111, 1, 0, 0, 0, 1);
        addVec("D_b4",    1, 1, 1, 1, 5'd3, 0, 6'b110111, 1, 0, 0, 0, 1);
`ifdef FLAG_FWD_EN
        addVec("D_b5",    1, 1, 1, 1, 5'd3, 0, 6'b001000, 0, 0, 1, 1, 1);
`else
        addVec("D_b5",    1, 1, 1, 1, 5'd3, 0, 6'b001000, 1, 0, 0, 0, 1);
        addVec("D_b6",    1, 1, 1, 1, 5'd3, 0, 6'b001000, 0, 0, 1, 1, 0);
`endif
        addVec("D_f1",    1, 0, 0, 0, 5'd0, 0, 6'b001000, 0, 1, 0, 0, 0);
        addVec("D_f2",    1, 0, 0, 0, 5'd0, 0, 6'b001000, 0, 1, 0, 0, 0);
        addVec("D_n",     1, 0, 0, 0, 5'd0, 0, 6'b001000, 0, 0, 0, 0, 0);
        // Unimplemented codes never take; code 5 is the last real flag (0 now).
        addVec("E_jt7",   1, 1, 1, 1, 5'd7, 0, 6'b001000, 0, 0, 1, 0, 0);
        addVec("E_jf7",   1, 1, 1, 0, 5'd7, 0, 6'b001000, 0, 0, 1, 0, 0);
        addVec("E_jt6",   1, 1, 1, 1, 5'd6, 0, 6'b001000, 0, 0, 1, 0, 0);
        addVec("E_n",     1, 0, 0, 0, 5'd0, 0, 6'b001000, 0, 0, 0, 0, 0);
        addVec("E_jf5",   1, 1, 1, 0, 5'd5, 0, 6'b001000, 0, 0, 1, 1, 0);
        addVec("E_f1",    1, 0, 0, 0, 5'd0, 0, 6'b001000, 0, 1, 0, 0, 0);
        addVec("E_f2",    1, 0, 0, 0, 5'd0, 0, 6'b001000, 0, 1, 0, 0, 0);
        addVec("E_n2",    1, 0, 0, 0, 5'd0, 0, 6'b001000, 0, 0, 0, 0, 0);
        // Reset mid-WAIT drops the pending writer; reset mid-FLUSH ends it.
        addVec("F_wr",    1, 1, 0, 0, 5'd0, 1, 6'b000000, 0, 0, 0, 0, 0);
        addVec("F_n",     1, 0, 0, 0, 5'd0, 0, 6'b000000, 0, 0, 0, 0, 0);
        addVec("F_br",    1, 1, 1, 1, 5'd3, 0, 6'b000000, 1, 0, 0, 0, 0);
        addVec("F_rst",   0, 1, 1, 1, 5'd3, 0, 6'b000000, 0, 0, 0, 0, 0);
        addVec("F_br2",   1, 1, 1, 1, 5'd3, 0, 6'b000000, 0, 0, 1, 1, 0);
        addVec("F_rst2",  0, 0, 0, 0, 5'd0, 0, 6'b000000, 0, 0, 0, 0, 0);
        addVec("F_n2",    1, 0, 0, 0, 5'd0, 0, 6'b000000, 0, 0, 0, 0, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n           = v.rst;
        id_valid        = v.valid;
        id_is_branch    = v.br;
        id_sel_jt_jf    = v.sel;
        id_flag_code    = v.code;
        id_writes_flags = v.wr;
        wb_flags        = v.wb;
        exp_q.push_back(v);
    endtask

    task automatic checkBit(input string row, input string sig,
                            input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%0b expected=%0b", row, sig, actual, expected);
        end
    endtask

    task automatic checkOutput();
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty actual=0 entries expected=1 entry");
        end else begin
            e = exp_q.pop_front();
            checkBit(e.name, "stall",       stall,       e.e_stall);
            checkBit(e.name, "flush",       flush,       e.e_flush);
            checkBit(e.name, "br_resolved", br_resolved, e.e_res);
            checkBit(e.name, "fmu_we",      fmu_we,      e.e_we);
            if (e.e_res) checkBit(e.name, "br_taken", br_taken, e.e_taken);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        id_valid        = 1'b0;
        id_is_branch    = 1'b0;
        id_sel_jt_jf    = 1'b0;
        id_flag_code    = 5'd0;
        id_writes_flags = 1'b0;
        wb_flags        = 6'd0;
        buildTable();
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flag_branch_ctrl.md
Name: flag_branch_ctrl

Overview:
- Controller that sequences the flag management unit (FMU) for conditional jumps (jt/jf).
- Tracks in-flight flag-writing instructions between ID and flag commit, and drives the FMU write enable, flag select and jt/jf select.
- Stalls a branch in ID until its flags are architecturally valid, then resolves it and requests a front-end flush when taken.
- Sits between the decode stage, the writeback flag path and the FMU.

Parameters:
- PIPE_DEPTH, 3: cycles from a flag writer leaving ID to its FMU commit cycle (≥1).
- FLUSH_CYCLES, 2: cycles flush is held after a taken branch (≥1).
- FLAG_W, 6: number of implemented flag bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- id_valid  in  1  valid instruction in ID.
- id_is_branch  in  1  ID instruction is jt/jf.
- id_sel_jt_jf  in  1  1 = jt, 0 = jf.
- id_flag_code  in  5  flag index tested by the branch.
- id_writes_flags  in  1  ID instruction updates flags.
- wb_flags  in  FLAG_W  ALU flags at commit stage (FMU flags_in).
- fmu_jt_jf_ok  in  1  FMU condition result.
- fmu_we  out  1  FMU write enable.
- fmu_flag_code  out  5  flag select to FMU.
- fmu_sel_jt_jf  out  1  jt/jf select to FMU.
- stall  out  1  hold IF/ID.
- flush  out  1  kill IF/ID contents.
- br_resolved  out  1  one-cycle pulse: branch decided.
- br_taken  out  1  decision; valid only with br_resolved.

Behaviour:
- Scoreboard: pend[PIPE_DEPTH-1:0] shifts toward the MSB every cycle.
  - Bit 0 loads issue = id_valid & id_writes_flags & ~stall & ~flush; otherwise a bubble (0) enters.
  - fmu_we = pend[PIPE_DEPTH-1]. The FMU is updated at the end of that cycle.
  - pend == 0 means all flags are committed.
- FSM states: IDLE, WAIT, FLUSH.
- IDLE:
  - fmu_flag_code/fmu_sel_jt_jf track the id_* inputs.
  - On id_valid & id_is_branch:
    - pend == 0: resolve this cycle. br_resolved = 1, br_taken = cond. Taken → FLUSH; else stay IDLE.
    - pend != 0: latch code and sel, stall = 1, go to WAIT.
- WAIT:
  - stall = 1 and the FMU is driven from the latched code/sel.
  - When pend == 0, resolve that cycle: stall = 0, br_resolved = 1. Taken → FLUSH; else → IDLE.
- FLUSH:
  - flush = 1 for FLUSH_CYCLES cycles (down-counter), stall = 0.
  - id_* inputs are ignored (treated as invalid). Then → IDLE.
- Condition:
  - cond = fmu_jt_jf_ok when code < FLAG_W.
  - When code ≥ FLAG_W, cond = 0 for both jt and jf, so the branch is not taken.
- A branch that also writes flags is illegal; id_writes_flags is ignored when id_is_branch = 1.
- Reset (synchronous, any state, including mid-WAIT or mid-FLUSH):
  - FSM → IDLE, pend = 0, counter = 0.
  - stall, flush, br_resolved, br_taken, fmu_we = 0.
  - fmu_flag_code and fmu_sel_jt_jf follow the id_* inputs.
- Latency: 0 cycles with no pending writer. Otherwise resolution occurs in the cycle after the last pending fmu_we.

Optional Feature:
- FLAG_FWD_EN defined: when pend has only its MSB set (writer committing this cycle), the branch resolves in that cycle.
  - cond is taken from wb_flags[code] (inverted for jf) instead of fmu_jt_jf_ok, saving one stall cycle.
  - The code ≥ FLAG_W rule still applies.
- FLAG_FWD_EN undefined: resolution waits for pend == 0.

Decomposition:
- Shared package/defs file holds:
  - FSM state encodings (ST_IDLE, ST_WAIT, ST_FLUSH).
  - FLAG_REG_WIDTH (= FLAG_W default) and the flag index constants.
- One natural sub-module: flag_scoreboard (pend shift register plus fmu_we/empty/last-only outputs).

Test Plan:
- pend = 0, flags = 6'b000001, jt code 0 → br_resolved & br_taken in the same cycle; flush high exactly 2 cycles; no stall.
- Writer issued at cycle 0, jt in ID at cycle 1 (PIPE_DEPTH = 3):
  - stall in cycles 1–3, fmu_we in cycle 3, resolve in cycle 4.
  - With FLAG_FWD_EN: stall in cycles 1–2, resolve in cycle 3 from wb_flags.
- jf on flag 2 with flags = 6'b000100 → br_resolved = 1, br_taken = 0, flush never asserted, FSM back to IDLE.
- Three consecutive writers, then a branch → stall until pend drains; exactly three fmu_we pulses; resolution uses the last writer's flags.
- Branch with id_flag_code = 5'd7 → not taken for both jt and jf; no flush.
- rst_n low during WAIT → next cycle: IDLE, stall = 0, pend = 0, fmu_we = 0; a later branch resolves immediately.
